// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters, registered display-enable and
// line/frame strobes, and hs/vs delayed to line up with registered downstream RGB.
module vga_timing_gen #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int SYNC_DELAY = 1
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    input  logic       pix_en,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       line_end,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024 || SYNC_DELAY > 4 || SYNC_DELAY < 0) begin : g_param_check
            $error("vga_timing_gen: totals must fit 10 bits and SYNC_DELAY must be 0..4");
        end
    endgenerate

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_END  = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS_END  = 10'(V_VISIBLE);
    localparam logic [9:0] HS_FIRST   = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_LAST    = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST   = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_LAST    = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

    logic [9:0] x_next;
    logic [9:0] y_next;
    logic [7:0] fc_next;
    logic       blank_next;
    logic       hsync_next;
    logic       vsync_next;
    logic       line_end_next;
    logic       frame_start_next;

    // Element 0 is aligned with DrawX/DrawY; element SYNC_DELAY drives the pins.
    logic [SYNC_DELAY:0] hs_pipe;
    logic [SYNC_DELAY:0] vs_pipe;

    // Next-count and decode: everything below is registered from these values,
    // so the decoded flags share the counters' timing.
    always_comb begin
        x_next  = DrawX + 10'd1;
        y_next  = DrawY;
        fc_next = frame_count;
        if (DrawX == H_LAST) begin
            x_next = 10'd0;
            if (DrawY == V_LAST) begin
                y_next  = 10'd0;
                fc_next = frame_count + 8'd1;
            end else begin
                y_next = DrawY + 10'd1;
            end
        end
        blank_next       = (x_next < H_VIS_END) && (y_next < V_VIS_END);
        hsync_next       = !((x_next >= HS_FIRST) && (x_next <= HS_LAST));
        vsync_next       = !((y_next >= VS_FIRST) && (y_next <= VS_LAST));
        line_end_next    = (x_next == H_LAST);
        frame_start_next = (x_next == 10'd0) && (y_next == 10'd0);
    end

    // Counter / decode register stage and sync delay line
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            DrawX       <= 10'd0;
            DrawY       <= 10'd0;
            frame_count <= 8'd0;
            blank       <= 1'b0;
            line_end    <= 1'b0;
            frame_start <= 1'b0;
            hs_pipe     <= '1;
            vs_pipe     <= '1;
        end else if (pix_en) begin
            DrawX       <= x_next;
            DrawY       <= y_next;
            frame_count <= fc_next;
            blank       <= blank_next;
            line_end    <= line_end_next;
            frame_start <= frame_start_next;
            hs_pipe[0]  <= hsync_next;
            vs_pipe[0]  <= vsync_next;
            for (int i = 1; i <= SYNC_DELAY; i++) begin
                hs_pipe[i] <= hs_pipe[i-1];
                vs_pipe[i] <= vs_pipe[i-1];
            end
        end
    end

    assign hs = hs_pipe[SYNC_DELAY];
    assign vs = vs_pipe[SYNC_DELAY];

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Raster timing generator directly upstream of every sprite/colour stage.
- Produces DrawX, DrawY and blank (display-enable, 1 = visible) for the sprite stages that sit downstream of it.
- Produces hs/vs for the VGA connector, delayed to line up with the one-cycle registered RGB of the sprite stages.
- Also provides frame/line strobes and a frame counter for the game logic.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch (H_TOTAL = 800)
- V_VISIBLE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch (V_TOTAL = 525)
- SYNC_DELAY, 1, extra pixel-enable cycles applied to hs/vs (legal 0..4)

Ports:
- vga_clk  in  1  pixel-domain clock
- reset_n  in  1  asynchronous active-low reset
- pix_en  in  1  pixel advance enable; 1 every cycle when vga_clk is already the pixel rate
- DrawX  out  10  current horizontal count, 0..H_TOTAL-1
- DrawY  out  10  current vertical count, 0..V_TOTAL-1
- blank  out  1  1 when DrawX<H_VISIBLE and DrawY<V_VISIBLE
- hs  out  1  horizontal sync, active low, delayed SYNC_DELAY
- vs  out  1  vertical sync, active low, delayed SYNC_DELAY
- line_end  out  1  one-pixel strobe while DrawX==H_TOTAL-1
- frame_start  out  1  one-pixel strobe while DrawX==0 and DrawY==0
- frame_count  out  8  completed-frame counter, wraps 255->0

Behaviour:
- Reset (reset_n=0, asynchronous):
  - DrawX=0, DrawY=0, blank=0, hs=1, vs=1, line_end=0, frame_start=0, frame_count=0.
  - All sync delay stages are set to 1.
- Counters:
  - On posedge vga_clk with pix_en=1, DrawX increments.
  - At H_TOTAL-1, DrawX wraps to 0 and DrawY increments.
  - At V_TOTAL-1 with DrawX at H_TOTAL-1, DrawY wraps to 0 and frame_count increments, mod 256.
  - With pix_en=0, every output holds, including the delay pipeline and the strobes.
- Decode:
  - blank, line_end, frame_start and the undelayed sync terms are registered from the next-count value, so they are exactly aligned with DrawX/DrawY. There is no combinational path from the counters.
  - Raw hsync = 0 for DrawX in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC-1], i.e. [656, 751].
  - Raw vsync = 0 for DrawY in [V_VISIBLE+V_FP, V_VISIBLE+V_FP+V_SYNC-1], i.e. [490, 491].
- Sync delay:
  - Raw hsync/vsync pass through a SYNC_DELAY-deep shift register that advances only on pix_en.
  - SYNC_DELAY=0 makes hs/vs aligned with DrawX/DrawY.
  - Default 1 matches the registered RGB of a downstream sprite stage.
- Post-reset boundary:
  - The first pix_en edge after reset release moves the counters to (1,0) with blank=1.
  - Pixel (0,0) of the first frame is therefore presented with blank=0.
  - No frame_start pulse occurs until the first wrap, i.e. after 420000 pix_en cycles at defaults.
- Simultaneous end-of-line and end-of-frame:
  - line_end=1 at (799,524).
  - The next enabled edge gives (0,0), frame_start=1 and frame_count+1, all on the same edge.
- Reset mid-frame: immediately returns to the reset values. No partial-frame count is recorded.
- Width rule: 10-bit counters; elaboration fails if H_TOTAL or V_TOTAL > 1024, or if SYNC_DELAY > 4.

Test Plan:
1. Release reset, pix_en=1 continuously. Sample after 1, 639 and 640 edges: (1,0) with blank=1; (639,0) with blank=1; (640,0) with blank=0.
2. Horizontal sync, SYNC_DELAY=1: hs falls one edge after DrawX reaches 656 and rises one edge after DrawX reaches 752. The low pulse is 96 cycles. The same check with SYNC_DELAY=0 gives zero offset.
3. Vertical sync: vs is low for exactly 1600 pixels. It starts one pixel after (0,490) and ends one pixel after (0,492).
4. Frame wrap: run 420000 edges. DrawX/DrawY go (799,524) -> (0,0). line_end=1 on the first, frame_start=1 on the second, frame_count 0->1. Repeat 256 frames: frame_count returns to 0.
5. Enable gating: pix_en toggles 1,0,1,0 (divide-by-2). DrawX advances once per two cycles, all outputs hold on disabled cycles, and the hs pulse measures 192 clocks.
6. Reset mid-frame: assert reset_n=0 asynchronously at (300,200) with frame_count=3. Outputs go to reset values before the next clock edge: hs=1, vs=1, frame_count=0.
